// File: rtl/inst_enc_pkg.sv
`default_nettype none
// ============================================================================
// Package : inst_enc_pkg
// Brief   : RV32I subset op codes, encoding fields and loader FSM states.
// Rev     : 1.0
// ============================================================================
package inst_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_XOR  = 4'd1,
        OP_OR   = 4'd2,
        OP_ADDI = 4'd3,
        OP_XORI = 4'd4,
        OP_SLLI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_BLT  = 4'd9,
        OP_BGE  = 4'd10,
        OP_JAL  = 4'd11,
        OP_JALR = 4'd12,
        OP_LUI  = 4'd13
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [6:0] c_opc_reg    = 7'b0110011;
    localparam logic [6:0] c_opc_imm    = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;

    localparam logic [2:0] c_f3_add  = 3'b000;
    localparam logic [2:0] c_f3_sll  = 3'b001;
    localparam logic [2:0] c_f3_word = 3'b010;
    localparam logic [2:0] c_f3_xor  = 3'b100;
    localparam logic [2:0] c_f3_or   = 3'b110;
    localparam logic [2:0] c_f3_beq  = 3'b000;
    localparam logic [2:0] c_f3_blt  = 3'b100;
    localparam logic [2:0] c_f3_bge  = 3'b101;
    localparam logic [2:0] c_f3_jalr = 3'b000;

    localparam logic [6:0]  c_f7_zero = 7'b0000000;
    localparam logic [31:0] c_nop     = 32'h0000_0013;

    // True when v is representable as a signed value whose sign bit is bit msb.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
        logic [31:0] top;
        top = $signed(v) >>> msb;
        return (top == '0) || (top == '1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : inst_encoder_loader_if
// Brief     : Host request channel plus instruction-memory write port.
// Rev       : 1.0
// ============================================================================
interface inst_encoder_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module : inst_encoder
// Brief  : Combinational RV32I-subset encoder with immediate range checking.
// Rev    : 1.0
// ============================================================================
module inst_encoder
    import inst_enc_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_range_err,
    output logic        o_illegal
);

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], c_opc_branch};
    endfunction

    logic w_b_range_err;
    logic w_i_range_err;

    assign w_i_range_err = !fits_signed(i_imm, 11);
    assign w_b_range_err = !fits_signed(i_imm, 12) || i_imm[0];

    always_comb begin
        o_word      = c_nop;
        o_range_err = 1'b0;
        o_illegal   = 1'b0;
        case (i_op)
            OP_ADD:  o_word = {c_f7_zero, i_rs2, i_rs1, c_f3_add, i_rd, c_opc_reg};
            OP_XOR:  o_word = {c_f7_zero, i_rs2, i_rs1, c_f3_xor, i_rd, c_opc_reg};
            OP_OR:   o_word = {c_f7_zero, i_rs2, i_rs1, c_f3_or,  i_rd, c_opc_reg};
            OP_ADDI: begin
                o_word      = {i_imm[11:0], i_rs1, c_f3_add, i_rd, c_opc_imm};
                o_range_err = w_i_range_err;
            end
            OP_XORI: begin
                o_word      = {i_imm[11:0], i_rs1, c_f3_xor, i_rd, c_opc_imm};
                o_range_err = w_i_range_err;
            end
            OP_SLLI: begin
                o_word      = {c_f7_zero, i_imm[4:0], i_rs1, c_f3_sll, i_rd, c_opc_imm};
                o_range_err = (i_imm[31:5] != '0);
            end
            OP_LW: begin
                o_word      = {i_imm[11:0], i_rs1, c_f3_word, i_rd, c_opc_load};
                o_range_err = w_i_range_err;
            end
            OP_SW: begin
                o_word      = {i_imm[11:5], i_rs2, i_rs1, c_f3_word, i_imm[4:0], c_opc_store};
                o_range_err = w_i_range_err;
            end
            OP_BEQ: begin
                o_word      = enc_b(i_imm, i_rs1, i_rs2, c_f3_beq);
                o_range_err = w_b_range_err;
            end
            OP_BLT: begin
                o_word      = enc_b(i_imm, i_rs1, i_rs2, c_f3_blt);
                o_range_err = w_b_range_err;
            end
            OP_BGE: begin
                o_word      = enc_b(i_imm, i_rs1, i_rs2, c_f3_bge);
                o_range_err = w_b_range_err;
            end
            OP_JAL: begin
                o_word      = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, c_opc_jal};
                o_range_err = !fits_signed(i_imm, 20) || i_imm[0];
            end
            OP_JALR: begin
                o_word      = {i_imm[11:0], i_rs1, c_f3_jalr, i_rd, c_opc_jalr};
                o_range_err = w_i_range_err;
            end
            OP_LUI: begin
                o_word      = {i_imm[19:0], i_rd, c_opc_lui};
                o_range_err = (i_imm[31:20] != '0);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/inst_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module : inst_encoder_loader
// Brief  : Session FSM streaming encoded instructions into instruction memory.
// Rev    : 1.0
// ============================================================================
module inst_encoder_loader
    import inst_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    inst_encoder_loader_if.slave   bus,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_W:0]        count
);

    localparam logic [ADDR_W-1:0] c_addr_top = '1;
    localparam logic [ADDR_W-1:0] c_addr_one = 1;
    localparam logic [ADDR_W:0]   c_cnt_one  = 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_im_we;
    logic [ADDR_W-1:0]  r_im_addr;
    logic [31:0]        r_im_wdata;
    logic               r_done;
    logic               r_err;
    logic [ADDR_W:0]    r_count;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_at_top;
    logic               w_open;
    logic [31:0]        w_word;
    logic               w_range_err;
    logic               w_illegal;

    inst_encoder u_encoder (
        .i_op        (bus.in_op),
        .i_rd        (bus.in_rd),
        .i_rs1       (bus.in_rs1),
        .i_rs2       (bus.in_rs2),
        .i_imm       (bus.in_imm),
        .o_word      (w_word),
        .o_range_err (w_range_err),
        .o_illegal   (w_illegal)
    );

    assign w_in_ready = (r_state == ST_LOAD);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_at_top   = (r_addr == c_addr_top);
    assign w_open     = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_LOAD;
            ST_LOAD:  if (w_accept && (bus.in_last || w_at_top)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output register stage: an accept at edge N presents the write during cycle N+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
        end else begin
            r_im_we <= w_accept;
            r_done  <= (r_state == ST_DRAIN);
            if (w_accept) begin
                r_im_addr  <= r_addr;
                r_im_wdata <= w_word;
                r_addr     <= r_addr + c_addr_one;
            end
            if (w_open) begin
                r_addr  <= '0;
                r_count <= '0;
                r_err   <= 1'b0;
            end else begin
                if (r_im_we) r_count <= r_count + c_cnt_one;
                // Running out of address space without in_last is an overflow.
                if (w_accept && (w_range_err || w_illegal || (w_at_top && !bus.in_last)))
                    r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.im_we    = r_im_we;
    assign bus.im_addr  = r_im_addr;
    assign bus.im_wdata = r_im_wdata;
    assign busy         = (r_state != ST_IDLE);
    assign cpu_hold     = (r_state != ST_IDLE);
    assign done         = r_done;
    assign err          = r_err;
    assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_encoder_loader
// Brief  : Vector-table and scoreboard bench for inst_encoder_loader.
// Rev    : 1.0
// ============================================================================
module tb_inst_encoder_loader;

    localparam int ADDR_W = 2;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        last;
        logic [31:0] word;
        logic        e;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    int                errors = 0;
    int                checks = 0;
    wr_t               sb[$];
    logic [ADDR_W-1:0] exp_addr;
    vec_t              vecs[14];

    always #5 clk = ~clk;

    inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                                input logic [31:0] word, input logic e);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.last = last; v.word = word; v.e = e;
        return v;
    endfunction

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin : mon
        wr_t w;
        if (!rst && bus.im_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL im_we: unexpected write addr=%0d data=0x%08h, expected none",
                         bus.im_addr, bus.im_wdata);
            end else begin
                w = sb.pop_front();
                check("im_addr", 32'(bus.im_addr), 32'(w.addr));
                check("im_wdata", bus.im_wdata, w.word);
            end
        end
    end

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_rd    = '0;
        bus.in_rs1   = '0;
        bus.in_rs2   = '0;
        bus.in_imm   = '0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_addr = '0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("hold_after_start", 32'(cpu_hold), 32'd1);
    endtask

    task automatic send(input vec_t v);
        int  n;
        wr_t w;
        bus.in_valid = 1'b1;
        bus.in_op    = v.op;
        bus.in_rd    = v.rd;
        bus.in_rs1   = v.rs1;
        bus.in_rs2   = v.rs2;
        bus.in_imm   = v.imm;
        bus.in_last  = v.last;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready timeout: got 0 expected 1");
        end else begin
            w.addr = exp_addr;
            w.word = v.word;
            sb.push_back(w);
            exp_addr++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_count, input logic exp_err, input logic restart);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done", 32'(done), 32'd1);
        check("count_at_done", 32'(count), 32'(exp_count));
        check("err_at_done", 32'(err), 32'(exp_err));
        check("busy_at_done", 32'(busy), 32'd0);
        check("hold_at_done", 32'(cpu_hold), 32'd0);
        check("writes_drained", 32'(sb.size()), 32'd0);
        if (restart) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            exp_addr = '0;
            check("restart_count", 32'(count), 32'd0);
            check("restart_busy", 32'(busy), 32'd1);
            check("restart_err", 32'(err), 32'd0);
        end else begin
            @(negedge clk);
            check("done_single_pulse", 32'(done), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        logic serr;

        vecs[0]  = mk(4'd3,  5'd1, 5'd0, 5'd0, 32'd5,          1'b0, 32'h00500093, 1'b0);
        vecs[1]  = mk(4'd0,  5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h002081B3, 1'b0);
        vecs[2]  = mk(4'd7,  5'd0, 5'd1, 5'd2, 32'd8,          1'b1, 32'h0020A423, 1'b0);
        vecs[3]  = mk(4'd8,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   1'b0, 32'hFE208EE3, 1'b0);
        vecs[4]  = mk(4'd11, 5'd1, 5'd0, 5'd0, 32'd8,          1'b0, 32'h008000EF, 1'b0);
        vecs[5]  = mk(4'd13, 5'd5, 5'd0, 5'd0, 32'h00012345,   1'b1, 32'h123452B7, 1'b0);
        vecs[6]  = mk(4'd3,  5'd1, 5'd0, 5'd0, 32'd2048,       1'b1, 32'h80000093, 1'b1);
        vecs[7]  = mk(4'd8,  5'd0, 5'd1, 5'd2, 32'd3,          1'b1, 32'h00208163, 1'b1);
        vecs[8]  = mk(4'd14, 5'd1, 5'd1, 5'd1, 32'd0,          1'b1, 32'h00000013, 1'b1);
        vecs[9]  = mk(4'd5,  5'd1, 5'd2, 5'd0, 32'd31,         1'b0, 32'h01F11093, 1'b0);
        vecs[10] = mk(4'd4,  5'd1, 5'd2, 5'd0, 32'hFFFFF800,   1'b0, 32'h80014093, 1'b0);
        vecs[11] = mk(4'd9,  5'd0, 5'd1, 5'd2, 32'd4094,       1'b0, 32'h7E20CFE3, 1'b0);
        vecs[12] = mk(4'd12, 5'd0, 5'd1, 5'd0, 32'd0,          1'b1, 32'h00008067, 1'b0);
        vecs[13] = mk(4'd2,  5'd3, 5'd1, 5'd2, 32'd0,          1'b1, 32'h0020E1B3, 1'b0);

        rst   = 1'b1;
        start = 1'b0;
        exp_addr = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_im_we", 32'(bus.im_we), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_im_addr", 32'(bus.im_addr), 32'd0);
        check("rst_im_wdata", bus.im_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        cnt  = 0;
        serr = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (cnt == 0) do_start();
            send(vecs[i]);
            cnt++;
            serr = serr | vecs[i].e;
            if (vecs[i].last) begin
                wait_done(cnt, serr, 1'b0);
                cnt  = 0;
                serr = 1'b0;
            end
        end

        // Overflow: four words into a four-word memory with no in_last.
        do_start();
        for (int i = 0; i < 4; i++) send(vecs[0]);
        check("ovf_in_ready", 32'(bus.in_ready), 32'd0);
        wait_done(4, 1'b1, 1'b0);

        // Gaps, ignored mid-session start, restart in the done cycle.
        do_start();
        send(vecs[1]);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("mid_start_count", 32'(count), 32'd1);
        check("mid_start_busy", 32'(busy), 32'd1);
        send(vecs[3]);
        @(posedge clk);
        #1;
        send(vecs[5]);
        wait_done(3, 1'b0, 1'b1);
        send(vecs[13]);
        wait_done(1, 1'b0, 1'b0);

        // Asynchronous reset with a write pending in the output stage.
        do_start();
        send(vecs[0]);
        send(vecs[1]);
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_op    = 4'd3;
        bus.in_last  = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_im_we", 32'(bus.im_we), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hold", 32'(cpu_hold), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
        do_start();
        send(vecs[2]);
        wait_done(1, 1'b0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
